// File: rtl/mem_commit_stage.sv
// Dual-slot MEM->commit stage: registers the slot pair and drives two register-file write ports.
// It also provides forwarding lookups. Optional retire counter: define RETIRE_CNT_EN.
// cmt_require slot i occupies [i*SLOT_W +: SLOT_W] as {result, write_reg_need, write_reg_addr}.
module mem_commit_stage #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned RADDR_W    = 5,
  parameter int unsigned NUM_LOOKUP = 4,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [1:0]                     in_valid,
  input  logic [2*(DATA_W+1+RADDR_W)-1:0] cmt_require,
  input  logic                           stall,
  input  logic                           flush,
  output logic [1:0]                     reg_we,
  output logic [2*RADDR_W-1:0]           reg_waddr,
  output logic [2*DATA_W-1:0]            reg_wdata,
  input  logic [NUM_LOOKUP*RADDR_W-1:0]  lk_addr,
  output logic [NUM_LOOKUP-1:0]          lk_hit,
  output logic [NUM_LOOKUP*DATA_W-1:0]   lk_data
`ifdef RETIRE_CNT_EN
  ,
  output logic [CNT_W-1:0]               retire_count
`endif
);

  localparam int unsigned SLOT_W = DATA_W + 1 + RADDR_W;

  if (CNT_W == 0) begin : g_cnt_w_check
    $error("CNT_W must be nonzero");
  end

  logic [1:0]         v_q, v_d;
  logic [1:0]         need_q, need_d;
  logic [RADDR_W-1:0] addr_q [2];
  logic [RADDR_W-1:0] addr_d [2];
  logic [DATA_W-1:0]  data_q [2];
  logic [DATA_W-1:0]  data_d [2];
  logic [1:0]         we_raw;

  // A stalled or flushed cycle inserts a bubble. The held payload is kept, so the
  // write ports and forwarding lookups see stable addr/data values.
  always_comb begin
    v_d = in_valid;
    for (int unsigned i = 0; i < 2; i++) begin
      addr_d[i] = cmt_require[i*SLOT_W +: RADDR_W];
      need_d[i] = cmt_require[i*SLOT_W + RADDR_W];
      data_d[i] = cmt_require[i*SLOT_W + RADDR_W + 1 +: DATA_W];
    end
    if (flush || stall) begin
      v_d    = '0;
      need_d = need_q;
      addr_d = addr_q;
      data_d = data_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_q    <= '0;
      need_q <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      v_q    <= v_d;
      need_q <= need_d;
      for (int unsigned i = 0; i < 2; i++) begin
        addr_q[i] <= addr_d[i];
        data_q[i] <= data_d[i];
      end
    end
  end

  // On a same-destination collision, the younger slot (1) wins.
  always_comb begin
    for (int unsigned i = 0; i < 2; i++) begin
      we_raw[i] = v_q[i] & need_q[i] & (addr_q[i] != '0);
    end
    reg_we[1] = we_raw[1];
    reg_we[0] = we_raw[0] & ~(we_raw[1] & (addr_q[1] == addr_q[0]));
    reg_waddr = {addr_q[1], addr_q[0]};
    reg_wdata = {data_q[1], data_q[0]};
  end

  always_comb begin
    lk_hit  = '0;
    lk_data = '0;
    for (int unsigned k = 0; k < NUM_LOOKUP; k++) begin
      if (reg_we[1] && (addr_q[1] == lk_addr[k*RADDR_W +: RADDR_W])) begin
        lk_hit[k]                  = 1'b1;
        lk_data[k*DATA_W +: DATA_W] = data_q[1];
      end else if (reg_we[0] && (addr_q[0] == lk_addr[k*RADDR_W +: RADDR_W])) begin
        lk_hit[k]                  = 1'b1;
        lk_data[k*DATA_W +: DATA_W] = data_q[0];
      end
    end
  end

`ifdef RETIRE_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counts every valid slot that retires, including slots that do not write a register.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(v_q[0]) + CNT_W'(v_q[1]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign retire_count = cnt_q;
`endif

endmodule

// File: tb/tb_mem_commit_stage.sv
// Self-checking bench for mem_commit_stage: table vectors, corner-case sequences and random stimulus.
// Every output is checked against a register-write map model that runs inside the bench.
module tb_mem_commit_stage;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NL = 4;
  localparam int CW = 4;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [1:0]           in_valid;
  logic [AW-1:0]        a0_r, a1_r;
  logic [DW-1:0]        d0_r, d1_r;
  logic                 n0_r, n1_r;
  logic                 st, fl;
  logic [2*(DW+1+AW)-1:0] cmt_require;
  logic [1:0]           reg_we;
  logic [2*AW-1:0]      reg_waddr;
  logic [2*DW-1:0]      reg_wdata;
  logic [NL*AW-1:0]     lk_addr;
  logic [NL-1:0]        lk_hit;
  logic [NL*DW-1:0]     lk_data;
`ifdef RETIRE_CNT_EN
  logic [CW-1:0]        retire_count;
`endif

  int vectors = 0;
  int miscompares = 0;

  assign cmt_require = {d1_r, n1_r, a1_r, d0_r, n0_r, a0_r};

  mem_commit_stage #(.DATA_W(DW), .RADDR_W(AW), .NUM_LOOKUP(NL), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .cmt_require(cmt_require),
    .stall(st), .flush(fl), .reg_we(reg_we), .reg_waddr(reg_waddr),
    .reg_wdata(reg_wdata), .lk_addr(lk_addr), .lk_hit(lk_hit), .lk_data(lk_data)
`ifdef RETIRE_CNT_EN
    , .retire_count(retire_count)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: the pending pair and a modulo-16 retire tally.
  bit [1:0]  mv;
  bit [1:0]  mn;
  bit [4:0]  ma [2];
  bit [31:0] md [2];
  int unsigned mcnt;

  always @(posedge clk) begin
    if (!rst_n) begin
      mv <= '0; mn <= '0; ma[0] <= '0; ma[1] <= '0; md[0] <= '0; md[1] <= '0;
      mcnt <= 0;
    end else begin
      mcnt <= (mcnt + mv[0] + mv[1]) % 16;
      if (fl || st) mv <= '0;
      else begin
        mv <= in_valid; mn <= {n1_r, n0_r};
        ma[0] <= a0_r; ma[1] <= a1_r; md[0] <= d0_r; md[1] <= d1_r;
      end
    end
  end

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Build the set of register writes from young to old; an address written by a younger slot is claimed.
  task automatic check_all(string tag);
    bit [1:0]   ewe = '0;
    bit [3:0]   eh = '0;
    bit [127:0] ed = '0;
    bit         claimed [32];
    bit [31:0]  owner [32];
    bit [4:0]   q;
    for (int i = 0; i < 32; i++) begin claimed[i] = 0; owner[i] = '0; end
    for (int s = 1; s >= 0; s--) begin
      if (mv[s] && mn[s] && ma[s] != 0 && !claimed[ma[s]]) begin
        ewe[s] = 1'b1; claimed[ma[s]] = 1'b1; owner[ma[s]] = md[s];
      end
    end
    for (int k = 0; k < NL; k++) begin
      q = lk_addr[k*AW +: AW];
      if (claimed[q]) begin eh[k] = 1'b1; ed[k*DW +: DW] = owner[q]; end
    end
    chk({tag, ".we"}, 128'(reg_we), 128'(ewe));
    chk({tag, ".waddr"}, 128'(reg_waddr), 128'({ma[1], ma[0]}));
    chk({tag, ".wdata"}, 128'(reg_wdata), 128'({md[1], md[0]}));
    chk({tag, ".lk_hit"}, 128'(lk_hit), 128'(eh));
    chk({tag, ".lk_data"}, 128'(lk_data), ed);
`ifdef RETIRE_CNT_EN
    chk({tag, ".retire"}, 128'(retire_count), 128'(mcnt));
`endif
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pair(logic [1:0] v, logic [4:0] a0, logic n0, logic [31:0] d0,
                          logic [4:0] a1, logic n1, logic [31:0] d1);
    in_valid = v; a0_r = a0; n0_r = n0; d0_r = d0; a1_r = a1; n1_r = n1; d1_r = d1;
  endtask

  typedef struct {
    logic [1:0]  v;
    logic [4:0]  a0, a1;
    logic        n0, n1;
    logic [31:0] d0, d1;
    logic        st, fl;
    logic [4:0]  lk0, lk1;
    logic [1:0]  we;
    logic [3:0]  hit;
    logic [31:0] fwd0;
  } vec_t;

  vec_t vt [9];

  initial begin
`ifdef RETIRE_CNT_EN
    logic [CW-1:0] c0;
`endif
    vt[0] = '{2'b11, 5'd7,  5'd7,  1'b1, 1'b1, 32'h11, 32'h22, 1'b0, 1'b0, 5'd7,  5'd0,  2'b10, 4'b0001, 32'h22};
    vt[1] = '{2'b11, 5'd0,  5'd4,  1'b1, 1'b0, 32'h12, 32'h34, 1'b0, 1'b0, 5'd0,  5'd4,  2'b00, 4'b0000, 32'h0};
    vt[2] = '{2'b11, 5'd3,  5'd9,  1'b1, 1'b1, 32'h33, 32'h99, 1'b0, 1'b0, 5'd3,  5'd9,  2'b11, 4'b0011, 32'h33};
    vt[3] = '{2'b10, 5'd3,  5'd3,  1'b1, 1'b1, 32'h44, 32'h55, 1'b0, 1'b0, 5'd3,  5'd0,  2'b10, 4'b0001, 32'h55};
    vt[4] = '{2'b01, 5'd3,  5'd3,  1'b1, 1'b1, 32'h66, 32'h77, 1'b0, 1'b0, 5'd3,  5'd0,  2'b01, 4'b0001, 32'h66};
    vt[5] = '{2'b11, 5'd8,  5'd9,  1'b1, 1'b1, 32'h88, 32'h89, 1'b1, 1'b0, 5'd8,  5'd0,  2'b00, 4'b0000, 32'h0};
    vt[6] = '{2'b11, 5'd8,  5'd9,  1'b1, 1'b1, 32'h88, 32'h89, 1'b0, 1'b1, 5'd9,  5'd0,  2'b00, 4'b0000, 32'h0};
    vt[7] = '{2'b11, 5'd20, 5'd21, 1'b0, 1'b0, 32'h20, 32'h21, 1'b0, 1'b0, 5'd20, 5'd0,  2'b00, 4'b0000, 32'h0};
    vt[8] = '{2'b11, 5'd31, 5'd1,  1'b1, 1'b1, 32'hAA, 32'hBB, 1'b0, 1'b0, 5'd1,  5'd31, 2'b11, 4'b0011, 32'hBB};

    // Reset held with a live pair on the inputs.
    rst_n = 1'b0; st = 1'b0; fl = 1'b0;
    set_pair(2'b11, 5'd3, 1'b1, 32'hDEAD, 5'd4, 1'b1, 32'hBEEF);
    lk_addr = {5'd0, 5'd0, 5'd4, 5'd3};
    for (int i = 0; i < 3; i++) begin
      step();
      chk("reset.we", 128'(reg_we), 128'(2'b00));
      chk("reset.lk_hit", 128'(lk_hit), 128'(4'b0000));
      check_all("reset");
    end
    rst_n = 1'b1;
    set_pair(2'b01, 5'd3, 1'b1, 32'hA5, 5'd0, 1'b0, 32'h0);
    step();
    chk("first.we", 128'(reg_we), 128'(2'b01));
    chk("first.waddr0", 128'(reg_waddr[4:0]), 128'(5'd3));
    chk("first.wdata0", 128'(reg_wdata[31:0]), 128'(32'hA5));
    check_all("first");

    for (int i = 0; i < 9; i++) begin
      set_pair(vt[i].v, vt[i].a0, vt[i].n0, vt[i].d0, vt[i].a1, vt[i].n1, vt[i].d1);
      st = vt[i].st; fl = vt[i].fl;
      lk_addr = {5'd0, 5'd0, vt[i].lk1, vt[i].lk0};
      step();
      chk($sformatf("vec%0d.we", i), 128'(reg_we), 128'(vt[i].we));
      chk($sformatf("vec%0d.hit", i), 128'(lk_hit), 128'(vt[i].hit));
      chk($sformatf("vec%0d.fwd0", i), 128'(lk_data[31:0]), 128'(vt[i].fwd0));
      check_all($sformatf("vec%0d", i));
    end
    st = 1'b0; fl = 1'b0;

    // Stall for two cycles; the pair must commit exactly once.
    set_pair(2'b11, 5'd10, 1'b1, 32'h1010, 5'd11, 1'b1, 32'h1111);
    lk_addr = {5'd0, 5'd0, 5'd11, 5'd10};
    st = 1'b1;
    step(); chk("stall1.we", 128'(reg_we), 128'(2'b00)); check_all("stall1");
    step(); chk("stall2.we", 128'(reg_we), 128'(2'b00)); check_all("stall2");
`ifdef RETIRE_CNT_EN
    c0 = retire_count;
`endif
    st = 1'b0;
    step(); chk("stall_go.we", 128'(reg_we), 128'(2'b11)); check_all("stall_go");
    in_valid = 2'b00;
    step(); chk("stall_after.we", 128'(reg_we), 128'(2'b00)); check_all("stall_after");
`ifdef RETIRE_CNT_EN
    chk("stall.retire_delta", 128'(retire_count - c0), 128'(4'd2));
`endif

    // Simultaneous flush and stall, then a normal pair.
    set_pair(2'b11, 5'd5, 1'b1, 32'h55, 5'd6, 1'b1, 32'h66);
    lk_addr = {5'd0, 5'd0, 5'd6, 5'd5};
    fl = 1'b1; st = 1'b1;
    step(); chk("flush.we", 128'(reg_we), 128'(2'b00)); check_all("flush");
    fl = 1'b0; st = 1'b0;
    set_pair(2'b11, 5'd12, 1'b1, 32'h1212, 5'd13, 1'b1, 32'h1313);
    lk_addr = {5'd0, 5'd0, 5'd13, 5'd12};
    step(); chk("postflush.we", 128'(reg_we), 128'(2'b11)); check_all("postflush");

    // Eight dual pairs plus one single pair: 17 retires wrap the 4-bit counter to 1.
    rst_n = 1'b0; step(); check_all("wrap_rst");
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      set_pair(2'b11, 5'(i + 1), 1'b1, 32'(i), 5'(i + 9), 1'b0, 32'(i + 100));
      step(); check_all("wrap_pair");
    end
    set_pair(2'b01, 5'd2, 1'b1, 32'h2, 5'd0, 1'b0, 32'h0);
    step(); check_all("wrap_single");
    in_valid = 2'b00;
    step(); check_all("wrap_idle");
`ifdef RETIRE_CNT_EN
    chk("wrap.retire", 128'(retire_count), 128'(4'd1));
`endif

    // Random stimulus with a narrow address range to provoke collisions and hits.
    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(0, 49) != 0);
      st = ($urandom_range(0, 5) == 0);
      fl = ($urandom_range(0, 7) == 0);
      set_pair(2'($urandom), 5'($urandom_range(0, 7)), 1'($urandom), $urandom,
               5'($urandom_range(0, 7)), 1'($urandom), $urandom);
      for (int k = 0; k < NL; k++) lk_addr[k*AW +: AW] = 5'($urandom_range(0, 7));
      step();
      check_all("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_commit_stage.md
Name: mem_commit_stage

Overview:
- Dual-slot MEM→commit pipeline register directly downstream of the memory stage.
- Latches the two per-slot commit requests (result, write_reg_need, write_reg_addr) and drives the two register-file write ports one cycle later.
- Resolves same-destination write collisions and suppresses writes to $0.
- Exposes a forwarding lookup so the issue/execute stages can bypass from the committing pair.

Parameters:
- DATA_W, 32, width of result/write data (matches REG_WIDTH).
- RADDR_W, 5, register address width.
- NUM_LOOKUP, 4, number of forwarding lookup ports.
- CNT_W, 32, retire counter width (used only with RETIRE_CNT_EN).

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  2  per-slot valid from the memory stage; bit1 = younger slot.
- cmt_require  in  CMT_REQUIRE[1:0]  per-slot result, write_reg_need, write_reg_addr.
- stall  in  1  upstream hold; the memory stage keeps its pair.
- flush  in  1  kill the pair being latched this cycle.
- reg_we  out  2  register-file write enables.
- reg_waddr  out  2×RADDR_W  write addresses.
- reg_wdata  out  2×DATA_W  write data.
- lk_addr  in  NUM_LOOKUP×RADDR_W  forwarding query addresses.
- lk_hit  out  NUM_LOOKUP  query matches a pending write.
- lk_data  out  NUM_LOOKUP×DATA_W  forwarded value.

Behaviour:
- Stage register: v[1:0], addr[1:0], data[1:0], need[1:0]. All updates are on the rising clk edge.
- Reset (rst_n=0 at an edge): v=0, addr=0, data=0, need=0. Hence reg_we=0, reg_waddr=0, reg_wdata=0, lk_hit=0, lk_data=0. Reset overrides everything, including a pair in flight.
- Load priority per edge:
  1. rst_n=0 → clear.
  2. flush=1 → v←0 (data don't-care, keep old).
  3. stall=1 → v←0 (bubble), so the held pair is committed exactly once, when it finally passes.
  4. Otherwise v←in_valid, addr/data/need←cmt_require.
- Latency: a request sampled at edge N drives reg_we/waddr/wdata during cycle N+1 (registered outputs, no combinational path from input to reg_we).
- Write enable generation:
  - we_raw[i] = v[i] & need[i] & (addr[i]≠0).
  - reg_we[1] = we_raw[1].
  - reg_we[0] = we_raw[0] & ~(we_raw[1] & addr[1]==addr[0]). The younger slot wins a collision and the older write is dropped.
- reg_waddr/reg_wdata always reflect the stage register contents, even when reg_we=0.
- Any in_valid pattern is legal, including 2'b10. Slots are processed independently.
- Forwarding, combinational from the stage register only:
  - Per lookup k: hit1 = reg_we[1] & addr[1]==lk_addr[k]; hit0 = reg_we[0] & addr[0]==lk_addr[k].
  - lk_hit[k] = hit1 | hit0.
  - lk_data[k] = hit1 ? data[1] : hit0 ? data[0] : 0.
  - lk_addr=0 never hits.
- Simultaneous flush and stall: flush takes precedence; the result is a bubble either way.

Optional Feature:
- Macro RETIRE_CNT_EN.
- Defined:
  - Adds output retire_count (CNT_W).
  - Reset to 0.
  - Each edge it adds popcount(v) of the pair currently in the stage register (0, 1 or 2), whether or not that pair writes a register.
  - Wraps modulo 2^CNT_W with no saturation.
- Undefined: port and logic absent; all other behaviour is identical.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with in_valid=2'b11 and stall=0, flush=0 → reg_we=0 and lk_hit=0 throughout. Release rst_n with slot0 {need=1, addr=3, result=0xA5} → reg_we=2'b01, reg_waddr[0]=3, reg_wdata[0]=0xA5 exactly one cycle later.
- Collision: both slots valid, addr=7, data0=0x11, data1=0x22 → reg_we=2'b10, wdata[1]=0x22. lk_addr=7 gives lk_hit=1, lk_data=0x22.
- $0 and need: slot0 addr=0 need=1, slot1 addr=4 need=0 → reg_we=2'b00. lk_addr=0 and lk_addr=4 both miss.
- Stall: pair P presented with stall=1 for 2 cycles, then stall=0 → reg_we=0 for 2 cycles, then P written once. With RETIRE_CNT_EN, retire_count increases by exactly 2.
- Flush: pair {addr 5 & 6, need=1} with flush=1 (and stall=1 simultaneously) → next cycle reg_we=0. The following unflushed pair commits normally.
- Counter wrap (RETIRE_CNT_EN, CNT_W=4): commit 8 dual pairs plus 1 single → retire_count=1.
